// File: rtl/bpsk_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bpsk_pkg
// Description : Shared definitions for the coherent BPSK demodulator:
//               FSM state encoding, default datapath sizing and the
//               bit-error-rate counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package bpsk_pkg;

    // Default sample width and samples per symbol
    localparam int DEF_WIDTH = 12;
    localparam int DEF_SPS   = 16;

    // Width of the BER bit/error counters
    localparam int BER_CNT_W = 16;

    // Demodulator FSM: waiting for a symbol start, or integrating a symbol
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/bpsk_correlator.sv
`default_nettype none
// ============================================================================
// Module      : bpsk_correlator
// Description : Signed sample x carrier multiply followed by a sign-extended
//               integrate-and-dump accumulator.
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous reset, active-low
//   i_signal   in   received sample (signed, WIDTH)
//   i_carrier  in   carrier reference (signed, WIDTH)
//   i_load     in   acc <= product (first sample of a symbol)
//   i_add      in   acc <= acc + product
//   i_clear    in   acc <= 0 (dump); highest priority
//   o_sum_ge0  out  (acc + product) >= 0, i.e. the decision on the
//                   integral including the sample presented this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module bpsk_correlator #(
    parameter int WIDTH     = 12,
    parameter int ACC_WIDTH = 28
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic signed [WIDTH-1:0] i_signal,
    input  logic signed [WIDTH-1:0] i_carrier,
    input  logic                    i_load,
    input  logic                    i_add,
    input  logic                    i_clear,
    output logic                    o_sum_ge0
);

    logic signed [2*WIDTH-1:0]   w_prod;
    logic signed [ACC_WIDTH-1:0] w_prod_ext;
    logic signed [ACC_WIDTH-1:0] w_sum;
    logic signed [ACC_WIDTH-1:0] r_acc;

    // Both operands are widened (sign-extending) to the full product width
    // so the multiply itself is carried out at 2*WIDTH bits.
    assign w_prod     = (2*WIDTH)'(i_signal) * (2*WIDTH)'(i_carrier);
    assign w_prod_ext = {{(ACC_WIDTH-2*WIDTH){w_prod[2*WIDTH-1]}}, w_prod};
    assign w_sum      = r_acc + w_prod_ext;

    // A tie at zero decides '1', so only the sign bit matters.
    assign o_sum_ge0  = ~w_sum[ACC_WIDTH-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (i_clear) begin
            r_acc <= '0;
        end else if (i_load) begin
            r_acc <= w_prod_ext;
        end else if (i_add) begin
            r_acc <= w_sum;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bpsk_demod.sv
`default_nettype none
// ============================================================================
// Module      : bpsk_demod
// Description : Coherent BPSK demodulator. Multiplies each received sample by
//               the local carrier, integrates over SPS samples and decides the
//               bit from the sign of the integral, with a 1-cycle bit_valid.
//   sychronizer    in   clock, rising edge
//   reset_n        in   asynchronous reset, active-low
//   signal_in      in   received sample (signed, WIDTH)
//   carrier_in     in   carrier reference from the DDS (signed, WIDTH)
//   sample_valid   in   inputs valid this cycle
//   symbol_start   in   (with sample_valid) first sample of a symbol
//   recovered_bit  out  decided bit, held until the next dump
//   bit_valid      out  1-cycle strobe, recovered_bit is new
//   sample_cnt     out  index of the next sample within the symbol
// Optional (macro BPSK_DEMOD_BER_EN):
//   expected_bit   in   reference bit, sampled at the dump edge
//   bit_count      out  saturating count of decided bits
//   err_count      out  saturating count of bits != expected_bit
// Revision    : 1.0 - initial release
// ============================================================================
module bpsk_demod
    import bpsk_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SPS   = DEF_SPS
) (
    input  logic                    sychronizer,
    input  logic                    reset_n,
    input  logic signed [WIDTH-1:0] signal_in,
    input  logic signed [WIDTH-1:0] carrier_in,
    input  logic                    sample_valid,
    input  logic                    symbol_start,
    output logic                    recovered_bit,
    output logic                    bit_valid,
    output logic [$clog2(SPS)-1:0]  sample_cnt
`ifdef BPSK_DEMOD_BER_EN
    ,
    input  logic                    expected_bit,
    output logic [BER_CNT_W-1:0]    bit_count,
    output logic [BER_CNT_W-1:0]    err_count
`endif
);

    localparam int ACC_WIDTH = 2*WIDTH + $clog2(SPS);
    localparam int CNT_W     = $clog2(SPS);
    localparam logic [CNT_W-1:0] c_last_idx = CNT_W'(SPS - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_bit;
    logic             r_bit_valid;

    logic w_start;
    logic w_add;
    logic w_dump;
    logic w_decision;

    // A qualified symbol_start always (re)loads, in any state, so a start on
    // the SPS-th sample overrides the dump.
    assign w_start = sample_valid & symbol_start;
    assign w_add   = sample_valid & ~symbol_start & (r_state == ACCUM);
    assign w_dump  = w_add & (r_cnt == c_last_idx);

    bpsk_correlator #(
        .WIDTH     (WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_correlator (
        .clk       (sychronizer),
        .rst_n     (reset_n),
        .i_signal  (signal_in),
        .i_carrier (carrier_in),
        .i_load    (w_start),
        .i_add     (w_add),
        .i_clear   (w_dump),
        .o_sum_ge0 (w_decision)
    );

    always_ff @(posedge sychronizer or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_bit       <= 1'b0;
            r_bit_valid <= 1'b0;
        end else begin
            r_bit_valid <= 1'b0;
            if (w_start) begin
                r_state <= ACCUM;
                r_cnt   <= CNT_W'(1);
            end else if (w_dump) begin
                r_state     <= IDLE;
                r_cnt       <= '0;
                r_bit       <= w_decision;
                r_bit_valid <= 1'b1;
            end else if (w_add) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign recovered_bit = r_bit;
    assign bit_valid     = r_bit_valid;
    assign sample_cnt    = r_cnt;

`ifdef BPSK_DEMOD_BER_EN
    logic [BER_CNT_W-1:0] r_bit_count;
    logic [BER_CNT_W-1:0] r_err_count;

    always_ff @(posedge sychronizer or negedge reset_n) begin
        if (!reset_n) begin
            r_bit_count <= '0;
            r_err_count <= '0;
        end else if (w_dump) begin
            if (r_bit_count != '1) begin
                r_bit_count <= r_bit_count + BER_CNT_W'(1);
            end
            if ((w_decision != expected_bit) && (r_err_count != '1)) begin
                r_err_count <= r_err_count + BER_CNT_W'(1);
            end
        end
    end

    assign bit_count = r_bit_count;
    assign err_count = r_err_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bpsk_demod.sv
`default_nettype none
// ============================================================================
// Module      : tb_bpsk_demod
// Description : Self-checking bench for bpsk_demod (WIDTH=12, SPS=16).
//               A symbol-level model (integer integral of accepted products)
//               is compared against the DUT on every falling clock edge;
//               directed scenarios add hand-computed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bpsk_demod;

    localparam int WIDTH = 12;
    localparam int SPS   = 16;

    logic                    sychronizer;
    logic                    reset_n;
    logic signed [WIDTH-1:0] signal_in;
    logic signed [WIDTH-1:0] carrier_in;
    logic                    sample_valid;
    logic                    symbol_start;
    logic                    recovered_bit;
    logic                    bit_valid;
    logic [$clog2(SPS)-1:0]  sample_cnt;
`ifdef BPSK_DEMOD_BER_EN
    logic                    expected_bit;
    logic [15:0]             bit_count;
    logic [15:0]             err_count;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int pulses   = 0;

    bpsk_demod #(
        .WIDTH (WIDTH),
        .SPS   (SPS)
    ) dut (
        .sychronizer   (sychronizer),
        .reset_n       (reset_n),
        .signal_in     (signal_in),
        .carrier_in    (carrier_in),
        .sample_valid  (sample_valid),
        .symbol_start  (symbol_start),
        .recovered_bit (recovered_bit),
        .bit_valid     (bit_valid),
        .sample_cnt    (sample_cnt)
`ifdef BPSK_DEMOD_BER_EN
        ,
        .expected_bit  (expected_bit),
        .bit_count     (bit_count),
        .err_count     (err_count)
`endif
    );

    initial sychronizer = 1'b0;
    always #5 sychronizer = ~sychronizer;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- symbol-level model ----------------
    bit     m_active;    // inside a symbol
    int     m_n;         // accepted samples of current symbol
    longint m_integral;  // sum of products so far
    longint m_last;      // integral of the last decided symbol
    bit     m_valid;
    bit     m_bit;
    int     m_bits;
    int     m_errs;

    always @(posedge sychronizer or negedge reset_n) begin
        if (!reset_n) begin
            m_active = 0; m_n = 0; m_integral = 0;
            m_valid = 0; m_bit = 0; m_bits = 0; m_errs = 0;
        end else begin
            m_valid = 0;
            if (sample_valid) begin
                if (symbol_start) begin
                    m_active = 1; m_n = 1;
                    m_integral = longint'(signal_in) * longint'(carrier_in);
                end else if (m_active) begin
                    m_integral += longint'(signal_in) * longint'(carrier_in);
                    m_n++;
                    if (m_n == SPS) begin
                        m_last   = m_integral;
                        m_bit    = (m_integral >= 0);
                        m_valid  = 1;
                        m_active = 0;
                        m_n      = 0;
                        m_integral = 0;
                        if (m_bits < 65535) m_bits++;
`ifdef BPSK_DEMOD_BER_EN
                        if (m_bit != expected_bit && m_errs < 65535) m_errs++;
`endif
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge sychronizer) begin
        check("bit_valid", longint'(bit_valid), longint'(m_valid));
        check("recovered_bit", longint'(recovered_bit), longint'(m_bit));
        check("sample_cnt", longint'(sample_cnt), longint'(m_n));
`ifdef BPSK_DEMOD_BER_EN
        check("bit_count", longint'(bit_count), longint'(m_bits));
        check("err_count", longint'(err_count), longint'(m_errs));
`endif
        if (bit_valid) pulses++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input bit v, input bit s, input int sig, input int car);
        sample_valid = v;
        symbol_start = s;
        signal_in    = WIDTH'(sig);
        carrier_in   = WIDTH'(car);
        @(posedge sychronizer);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0, 0);
    endtask

    task automatic symbol(input int sig, input int car);
        for (int i = 0; i < SPS; i++) drive(1'b1, i == 0, sig, car);
    endtask

    int p0;
    int vary[SPS] = '{300, -1200, 50, 2047, -2048, 7, -7, 1000,
                      -999, 1, 0, -1500, 800, -300, 120, -100};

    initial begin
        reset_n = 1'b1;
        sample_valid = 0; symbol_start = 0; signal_in = '0; carrier_in = '0;
`ifdef BPSK_DEMOD_BER_EN
        expected_bit = 0;
`endif
        #2 reset_n = 1'b0;
        #21 reset_n = 1'b1;
        @(posedge sychronizer); #1;
        check("reset bit_valid", longint'(bit_valid), 0);
        check("reset recovered_bit", longint'(recovered_bit), 0);
        check("reset sample_cnt", longint'(sample_cnt), 0);

        // 1: decide 1, followed zero-gap by a decide-0 symbol
        p0 = pulses;
        symbol(2047, 2047);
        check("t1 integral", m_last, 67043344);
        symbol(-2048, 2047);
        idle(1);
        check("t2 recovered_bit", longint'(recovered_bit), 0);
        check("t1/t2 pulse count", longint'(pulses - p0), 2);

        // mixed-sign samples against a fixed carrier
        for (int i = 0; i < SPS; i++) drive(1'b1, i == 0, vary[i], 1500);
        idle(2);

        // 3: gaps (inputs during gaps would flip the decision if used), carrier 0 -> tie -> 1
        p0 = pulses;
        for (int i = 0; i < SPS; i++) begin
            drive(1'b1, i == 0, 1000, 0);
            drive(1'b0, 1'b1, -2048, 2047);
        end
        idle(2);
        check("t3 pulse count", longint'(pulses - p0), 1);
        check("t3 tie integral", m_last, 0);
        check("t3 recovered_bit", longint'(recovered_bit), 1);

        // 4: resync on sample 9, aborted part strongly negative
        p0 = pulses;
        for (int i = 0; i < 8; i++) drive(1'b1, i == 0, -2048, 2047);
        for (int i = 0; i < SPS; i++) drive(1'b1, i == 0, 100, 2047);
        idle(2);
        check("t4 pulse count", longint'(pulses - p0), 1);
        check("t4 recovered_bit", longint'(recovered_bit), 1);

        // 4b: symbol_start on the SPS-th sample wins over the dump
        p0 = pulses;
        for (int i = 0; i < SPS - 1; i++) drive(1'b1, i == 0, -2048, 2047);
        for (int i = 0; i < SPS; i++) drive(1'b1, i == 0, 50, 2047);
        idle(2);
        check("t4b pulse count", longint'(pulses - p0), 1);
        check("t4b recovered_bit", longint'(recovered_bit), 1);

        // 5: asynchronous reset between edges mid-symbol
        for (int i = 0; i < 5; i++) drive(1'b1, i == 0, 2047, 2047);
        #2 reset_n = 1'b0;
        #1;
        check("t5 async bit_valid", longint'(bit_valid), 0);
        check("t5 async recovered_bit", longint'(recovered_bit), 0);
        check("t5 async sample_cnt", longint'(sample_cnt), 0);
        #4 reset_n = 1'b1;
        @(posedge sychronizer); #1;
        p0 = pulses;
        for (int i = 0; i < SPS; i++) drive(1'b1, 1'b0, 2047, 2047);
        check("t5 no start pulses", longint'(pulses - p0), 0);
        check("t5 no start sample_cnt", longint'(sample_cnt), 0);
        symbol(-2048, -2048);
        idle(1);
        check("t5 resume pulses", longint'(pulses - p0), 1);
        check("t5 resume bit", longint'(recovered_bit), 1);

`ifdef BPSK_DEMOD_BER_EN
        // 6: BER, 8 back-to-back symbols, expectation flipped on symbols 3 and 6
        #3 reset_n = 1'b0;
        #3 reset_n = 1'b1;
        @(posedge sychronizer); #1;
        for (int s = 0; s < 8; s++) begin
            expected_bit = ((s % 2) == 0) ^ (s == 2 || s == 5);
            symbol(((s % 2) == 0) ? 2047 : -2048, 2047);
        end
        idle(2);
        check("t6 bit_count", longint'(bit_count), 8);
        check("t6 err_count", longint'(err_count), 2);
`endif

        idle(2);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
